// File: rtl/car_request_if.sv
// Signal bundle between the loop-sensor request unit and its environment:
// raw sensor and controller lamps in, request/count/fault flags out.
interface car_request_if #(
  parameter int CNT_W = 4
);
  logic             sensor_raw;
  logic             green;
  logic             yellow;
  logic             red;
  logic             car_detect;
  logic [CNT_W-1:0] car_count;
  logic             sensor_fault;
  logic             illegal_lights;

  modport master (
    output sensor_raw, green, yellow, red,
    input  car_detect, car_count, sensor_fault, illegal_lights
  );

  modport slave (
    input  sensor_raw, green, yellow, red,
    output car_detect, car_count, sensor_fault, illegal_lights
  );
endinterface

// File: rtl/car_request_unit.sv
// Turns a bouncy loop-sensor line into the controller's car_detect request,
// tracks service via the lamp outputs and flags stuck sensors / bad lamp codes.
module car_request_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 64,
  parameter int CNT_W           = 4
) (
  input logic          clk,
  input logic          reset,
  car_request_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]    SCNT_MAX  = SW'(STUCK_CYCLES);
  localparam logic [SW-1:0]    SCNT_LAST = SW'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVED  = 2'd2
  } state_t;

  function automatic logic lamps_onehot(input logic [2:0] lamps);
    logic ok;
    case (lamps)
      3'b001:  ok = 1'b1;
      3'b010:  ok = 1'b1;
      3'b100:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic             s1;
  logic             s2;
  logic             filt;
  logic             filt_d;
  logic [DW-1:0]    dcnt;
  logic [SW-1:0]    scnt;
  logic             yellow_d;
  logic             green_d;
  logic             sensor_fault;
  logic             illegal_lights;
  logic             car_detect;
  logic [CNT_W-1:0] count;
  state_t           state;

  logic             arrival;
  logic             yellow_rise;
  logic             green_rise;
  logic             fault_next;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] count_calc;
  logic [CNT_W-1:0] count_next;
  state_t           state_next;

  assign arrival     = filt & ~filt_d & ~sensor_fault;
  assign yellow_rise = bus.yellow & ~yellow_d;
  assign green_rise  = bus.green & ~green_d;
  assign count_inc   = (count == CNT_MAX) ? CNT_MAX : count + CNT_ONE;
  // The fault is declared on the same edge scnt reaches STUCK_CYCLES.
  assign fault_next  = sensor_fault | (filt & (scnt == SCNT_LAST));

  // Two-flop synchronizer and debounce filter for the raw sensor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      dcnt   <= {DW{1'b0}};
    end else begin
      s1     <= bus.sensor_raw;
      s2     <= s1;
      filt_d <= filt;
      if (s2 == filt) begin
        dcnt <= {DW{1'b0}};
      end else if (dcnt == DCNT_LAST) begin
        filt <= s2;
        dcnt <= {DW{1'b0}};
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Stuck-sensor run counter, lamp history and the two sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt           <= {SW{1'b0}};
      sensor_fault   <= 1'b0;
      illegal_lights <= 1'b0;
      yellow_d       <= 1'b0;
      green_d        <= 1'b0;
    end else begin
      if (!filt) begin
        scnt <= {SW{1'b0}};
      end else if (scnt != SCNT_MAX) begin
        scnt <= scnt + SW'(1);
      end else begin
        scnt <= scnt;
      end
      sensor_fault   <= fault_next;
      illegal_lights <= illegal_lights | ~lamps_onehot({bus.green, bus.yellow, bus.red});
      yellow_d       <= bus.yellow;
      green_d        <= bus.green;
    end
  end

  // Request FSM next-state and waiting-car count.
  always_comb begin
    state_next = state;
    count_calc = count;
    case (state)
      IDLE: begin
        if (arrival) begin
          state_next = PENDING;
          count_calc = CNT_ONE;
        end else begin
          state_next = IDLE;
        end
      end
      PENDING: begin
        if (yellow_rise) begin
          state_next = SERVED;
          // A car arriving right as service starts waits for the next round.
          count_calc = arrival ? CNT_ONE : CNT_ZERO;
        end else if (arrival) begin
          count_calc = count_inc;
        end else begin
          count_calc = count;
        end
      end
      SERVED: begin
        if (arrival) begin
          count_calc = count_inc;
        end else begin
          count_calc = count;
        end
        if (green_rise) begin
          state_next = (count_calc != CNT_ZERO) ? PENDING : IDLE;
        end else begin
          state_next = SERVED;
        end
      end
      default: begin
        state_next = IDLE;
        count_calc = count;
      end
    endcase
    count_next = sensor_fault ? count : count_calc;
  end

  // State, count and the fail-safe request output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= CNT_ZERO;
      car_detect <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      car_detect <= fault_next | (state_next == PENDING);
    end
  end

  assign bus.car_detect     = car_detect;
  assign bus.car_count      = count;
  assign bus.sensor_fault   = sensor_fault;
  assign bus.illegal_lights = illegal_lights;

endmodule

// File: tb/tb_car_request_unit.sv
// Bench for car_request_unit: directed vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a behavioural model.
module tb_car_request_unit;

  localparam int D     = 4;
  localparam int STUCK = 64;
  localparam int CMAX  = 15;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  car_request_if #(.CNT_W(4)) bus ();

  car_request_unit #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(STUCK), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       raw;
    logic [2:0] gyr;
    logic       cd;
    int         cnt;
    logic       ill;
  } vec_t;

  vec_t vecs[29];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic lamps(input logic [2:0] gyr);
    bus.green  = gyr[2];
    bus.yellow = gyr[1];
    bus.red    = gyr[0];
  endtask

  task automatic pulse_car();
    bus.sensor_raw = 1'b1;
    step(6);
    bus.sensor_raw = 1'b0;
    step(8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model: debounced level from a window of synchronized samples,
  // service phase flags and a saturating arrival count.
  logic m_s1, m_s2, m_filt, m_filt_d, m_yd, m_gd, m_fault, m_ill, m_pend, m_served, m_cd;
  logic m_arr, m_yr, m_gr, m_fault_n, m_flip;
  int   m_cnt, m_run, m_c, m_lit;
  logic m_hist[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_s1, m_s2, m_filt, m_filt_d, m_yd, m_gd} = 6'b0;
      {m_fault, m_ill, m_pend, m_served, m_cd}   = 5'b0;
      m_cnt = 0;
      m_run = 0;
      m_hist.delete();
    end else begin
      m_arr     = m_filt & ~m_filt_d & ~m_fault;
      m_yr      = bus.yellow & ~m_yd;
      m_gr      = bus.green & ~m_gd;
      m_run     = m_filt ? m_run + 1 : 0;
      m_fault_n = m_fault | (m_run >= STUCK);
      m_c = m_cnt;
      if (m_pend) begin
        if (m_yr) begin
          m_pend = 1'b0;
          m_served = 1'b1;
          m_c = m_arr ? 1 : 0;
        end else if (m_arr) begin
          m_c = (m_c + 1 > CMAX) ? CMAX : m_c + 1;
        end
      end else if (m_served) begin
        if (m_arr) m_c = (m_c + 1 > CMAX) ? CMAX : m_c + 1;
        if (m_gr) begin
          m_served = 1'b0;
          m_pend = (m_c > 0);
        end
      end else if (m_arr) begin
        m_pend = 1'b1;
        m_c = 1;
      end
      if (!m_fault) m_cnt = m_c;
      m_lit = int'(bus.green) + int'(bus.yellow) + int'(bus.red);
      if (m_lit != 1) m_ill = 1'b1;
      m_filt_d = m_filt;
      m_hist.push_back(m_s2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      m_flip = (m_hist.size() == D);
      foreach (m_hist[k]) if (m_hist[k] == m_filt) m_flip = 1'b0;
      if (m_flip) m_filt = ~m_filt;
      m_s2    = m_s1;
      m_s1    = bus.sensor_raw;
      m_yd    = bus.yellow;
      m_gd    = bus.green;
      m_fault = m_fault_n;
      m_cd    = m_fault_n | m_pend;
    end
  end

  int raw_left, lamp_left, phase;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.sensor_raw = 1'b0;
    lamps(3'b100);

    // Row i: inputs before edge i after reset release, outputs after edge i.
    for (int i = 0; i < 29; i++) begin
      vecs[i].raw = 1'b0; vecs[i].gyr = 3'b100; vecs[i].cd = 1'b0;
      vecs[i].cnt = 0;    vecs[i].ill = 1'b0;
    end
    for (int i = 0; i <= 6; i++) vecs[i].raw = 1'b1;
    vecs[6].cd = 1'b1; vecs[6].cnt = 1;
    for (int i = 7; i <= 12; i++) begin vecs[i].cd = 1'b1; vecs[i].cnt = 1; end
    vecs[13].gyr = 3'b010; vecs[14].gyr = 3'b010;
    vecs[15].gyr = 3'b001; vecs[16].gyr = 3'b001;
    for (int i = 18; i <= 20; i++) vecs[i].raw = 1'b1;

    #2;
    check("reset car_detect", int'(bus.car_detect), 0);
    check("reset car_count", int'(bus.car_count), 0);
    check("reset sensor_fault", int'(bus.sensor_fault), 0);
    check("reset illegal_lights", int'(bus.illegal_lights), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      bus.sensor_raw = vecs[i].raw;
      lamps(vecs[i].gyr);
      step(1);
      check($sformatf("vec%0d car_detect", i), int'(bus.car_detect), int'(vecs[i].cd));
      check($sformatf("vec%0d car_count", i), int'(bus.car_count), vecs[i].cnt);
      check($sformatf("vec%0d illegal_lights", i), int'(bus.illegal_lights), int'(vecs[i].ill));
    end

    // Two arrivals during service, then green re-raises the request.
    pulse_car();
    check("new arrival car_detect", int'(bus.car_detect), 1);
    lamps(3'b010);
    step(2);
    check("served count", int'(bus.car_count), 0);
    pulse_car();
    lamps(3'b001);
    step(1);
    pulse_car();
    check("two waiting count", int'(bus.car_count), 2);
    check("two waiting car_detect", int'(bus.car_detect), 0);
    lamps(3'b100);
    step(1);
    check("green rerequest car_detect", int'(bus.car_detect), 1);
    check("green rerequest count", int'(bus.car_count), 2);

    // Arrival landing on the yellow-rise cycle.
    bus.sensor_raw = 1'b1;
    step(6);
    lamps(3'b010);
    step(1);
    check("same-cycle arrival count", int'(bus.car_count), 1);
    check("same-cycle arrival car_detect", int'(bus.car_detect), 0);
    bus.sensor_raw = 1'b0;
    step(8);
    lamps(3'b001);
    step(2);
    lamps(3'b100);
    step(1);
    check("carried car_detect", int'(bus.car_detect), 1);

    // Asynchronous reset while PENDING.
    reset = 1'b1;
    #1;
    check("midreset car_detect", int'(bus.car_detect), 0);
    check("midreset car_count", int'(bus.car_count), 0);
    check("midreset sensor_fault", int'(bus.sensor_fault), 0);
    check("midreset illegal_lights", int'(bus.illegal_lights), 0);
    @(negedge clk);
    reset = 1'b0;
    step(10);
    check("post reset idle car_detect", int'(bus.car_detect), 0);
    pulse_car();
    check("post reset arrival car_detect", int'(bus.car_detect), 1);
    check("post reset arrival count", int'(bus.car_count), 1);

    // Saturation, then a stuck-high sensor.
    repeat (20) pulse_car();
    check("saturated count", int'(bus.car_count), CMAX);
    bus.sensor_raw = 1'b1;
    step(40);
    check("stuck early fault", int'(bus.sensor_fault), 0);
    step(40);
    check("stuck fault", int'(bus.sensor_fault), 1);
    check("stuck car_detect", int'(bus.car_detect), 1);
    bus.sensor_raw = 1'b0;
    step(20);
    lamps(3'b010);
    step(3);
    check("fault sticky", int'(bus.sensor_fault), 1);
    check("fault forced car_detect", int'(bus.car_detect), 1);
    check("fault frozen count", int'(bus.car_count), CMAX);

    // Lamp one-hot checks.
    lamps(3'b100);
    do_reset();
    step(2);
    check("lamps legal", int'(bus.illegal_lights), 0);
    lamps(3'b000);
    step(1);
    check("lamps all-zero", int'(bus.illegal_lights), 1);
    lamps(3'b100);
    step(3);
    check("lamps sticky", int'(bus.illegal_lights), 1);
    do_reset();
    step(2);
    lamps(3'b110);
    step(1);
    check("lamps green+yellow", int'(bus.illegal_lights), 1);
    lamps(3'b100);

    // Random stimulus against the model.
    do_reset();
    raw_left  = 0;
    lamp_left = 0;
    phase     = 0;
    for (int i = 0; i < 2500; i++) begin
      if (raw_left == 0) begin
        bus.sensor_raw = ~bus.sensor_raw;
        raw_left = bus.sensor_raw ? $urandom_range(1, 12) : $urandom_range(1, 20);
      end
      raw_left--;
      if (i >= 2000 && i < 2120) bus.sensor_raw = 1'b1;
      if (lamp_left == 0) begin
        phase = (phase + 1) % 3;
        lamp_left = $urandom_range(1, 30);
      end
      lamp_left--;
      case (phase)
        0:       lamps(3'b100);
        1:       lamps(3'b010);
        default: lamps(3'b001);
      endcase
      if (i > 1200 && $urandom_range(0, 63) == 0) lamps(3'($urandom_range(0, 7)));
      reset = (i == 1000);
      step(1);
      check("rand car_detect", int'(bus.car_detect), int'(m_cd));
      check("rand car_count", int'(bus.car_count), m_cnt);
      check("rand sensor_fault", int'(bus.sensor_fault), int'(m_fault));
      check("rand illegal_lights", int'(bus.illegal_lights), int'(m_ill));
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
